// File: rtl/matmul_tile_sequencer_if.sv
// Bundle between the tile sequencer, its command source, the shared scratchpad and the
// systolic array. master = sequencer side, slave = environment side.
interface matmul_tile_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned M          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned K          = 3,
    parameter int unsigned ADDR_WIDTH = 12
);
    localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_a_base;
    logic [ADDR_WIDTH-1:0] cmd_b_base;
    logic [ADDR_WIDTH-1:0] cmd_c_base;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  mm_start;
    logic [DATA_WIDTH-1:0] mm_a_data;
    logic [MW-1:0]         mm_a_row;
    logic [KW-1:0]         mm_a_col;
    logic                  mm_a_valid;
    logic [DATA_WIDTH-1:0] mm_b_data;
    logic [KW-1:0]         mm_b_row;
    logic [NW-1:0]         mm_b_col;
    logic                  mm_b_valid;
    logic [DATA_WIDTH-1:0] mm_c_data;
    logic [MW-1:0]         mm_c_row;
    logic [NW-1:0]         mm_c_col;
    logic                  mm_c_valid;
    logic                  mm_done;
    logic                  busy;
    logic                  cmd_done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_c_base, rd_data,
               mm_c_data, mm_c_row, mm_c_col, mm_c_valid, mm_done,
        output cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, mm_start,
               mm_a_data, mm_a_row, mm_a_col, mm_a_valid,
               mm_b_data, mm_b_row, mm_b_col, mm_b_valid, busy, cmd_done, err
    );

    modport slave (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_c_base, rd_data,
               mm_c_data, mm_c_row, mm_c_col, mm_c_valid, mm_done,
        input  cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, mm_start,
               mm_a_data, mm_a_row, mm_a_col, mm_a_valid,
               mm_b_data, mm_b_row, mm_b_col, mm_b_valid, busy, cmd_done, err
    );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Command-driven controller for one systolic array: reads A and B row-major from the
// scratchpad, streams them into the array, and writes the returned C elements back.
module matmul_tile_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned M          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned K          = 3,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic                     clk,
    input logic                     rst_n,
    matmul_tile_sequencer_if.master bus
);
    localparam int unsigned MW     = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned NW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW     = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned MaxDim = (M > N) ? ((M > K) ? M : K) : ((N > K) ? N : K);
    localparam int unsigned IdxW   = $clog2(MaxDim + 1);
    localparam int unsigned CntW   = $clog2(M * N + 1) + 1;
    localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

    localparam logic [IdxW-1:0]       LastRowA = IdxW'(M - 1);
    localparam logic [IdxW-1:0]       LastColA = IdxW'(K - 1);
    localparam logic [IdxW-1:0]       LastRowB = IdxW'(K - 1);
    localparam logic [IdxW-1:0]       LastColB = IdxW'(N - 1);
    localparam logic [CntW-1:0]       CCount   = CntW'(M * N);
    localparam logic [TmoW-1:0]       TmoLast  = TmoW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] NAddr    = ADDR_WIDTH'(N);

    typedef enum logic [2:0] {StIdle, StStart, StLoadA, StLoadB, StWaitC} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_is_b_q;
    logic [IdxW-1:0]       rd_row_q, rd_col_q;
    logic                  a_valid_q, b_valid_q;
    logic [MW-1:0]         a_row_q;
    logic [KW-1:0]         a_col_q;
    logic [KW-1:0]         b_row_q;
    logic [NW-1:0]         b_col_q;
    logic                  mm_start_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CntW-1:0]       c_cnt_q;
    logic [TmoW-1:0]       tmo_q;
    logic                  cmd_done_q;
    logic                  err_q;

    logic                  c_take;
    logic [CntW-1:0]       c_cnt_eff;
    logic [ADDR_WIDTH-1:0] c_addr;

    // C capture qualification and write address; count includes a C element arriving with done
    always_comb begin
        c_take    = bus.mm_c_valid && ((state_q == StLoadB) || (state_q == StWaitC));
        c_cnt_eff = c_cnt_q + CntW'(c_take);
        c_addr    = c_base_q + ADDR_WIDTH'(bus.mm_c_row) * NAddr + ADDR_WIDTH'(bus.mm_c_col);
    end

    // Sequencer FSM with registered scratchpad, stream and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_is_b_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            a_row_q    <= '0;
            a_col_q    <= '0;
            b_row_q    <= '0;
            b_col_q    <= '0;
            mm_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            c_cnt_q    <= '0;
            tmo_q      <= '0;
            cmd_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mm_start_q <= 1'b0;
            cmd_done_q <= 1'b0;
            wr_en_q    <= 1'b0;
            // Each read's tag reappears on the stream alongside its data one cycle later
            a_valid_q  <= rd_en_q && !rd_is_b_q;
            b_valid_q  <= rd_en_q && rd_is_b_q;
            if (rd_en_q && !rd_is_b_q) begin
                a_row_q <= rd_row_q[MW-1:0];
                a_col_q <= rd_col_q[KW-1:0];
            end
            if (rd_en_q && rd_is_b_q) begin
                b_row_q <= rd_row_q[KW-1:0];
                b_col_q <= rd_col_q[NW-1:0];
            end
            if (c_take) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= c_addr;
                wr_data_q <= bus.mm_c_data;
                c_cnt_q   <= c_cnt_eff;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        a_base_q   <= bus.cmd_a_base;
                        b_base_q   <= bus.cmd_b_base;
                        c_base_q   <= bus.cmd_c_base;
                        err_q      <= 1'b0;
                        c_cnt_q    <= '0;
                        mm_start_q <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= a_base_q;
                    rd_row_q  <= '0;
                    rd_col_q  <= '0;
                    rd_is_b_q <= 1'b0;
                    state_q   <= StLoadA;
                end
                StLoadA: begin
                    // Row-major operands are contiguous, so the address simply increments
                    if (rd_row_q == LastRowA && rd_col_q == LastColA) begin
                        rd_addr_q <= b_base_q;
                        rd_row_q  <= '0;
                        rd_col_q  <= '0;
                        rd_is_b_q <= 1'b1;
                        state_q   <= StLoadB;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                        if (rd_col_q == LastColA) begin
                            rd_col_q <= '0;
                            rd_row_q <= rd_row_q + 1'b1;
                        end else begin
                            rd_col_q <= rd_col_q + 1'b1;
                        end
                    end
                end
                StLoadB: begin
                    if (rd_en_q) begin
                        if (rd_row_q == LastRowB && rd_col_q == LastColB) begin
                            rd_en_q <= 1'b0;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                            if (rd_col_q == LastColB) begin
                                rd_col_q <= '0;
                                rd_row_q <= rd_row_q + 1'b1;
                            end else begin
                                rd_col_q <= rd_col_q + 1'b1;
                            end
                        end
                    end else begin
                        // This cycle carries the last B element on the stream
                        tmo_q   <= '0;
                        state_q <= StWaitC;
                    end
                end
                StWaitC: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (bus.mm_done) begin
                        if (c_cnt_eff == CCount) begin
                            cmd_done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else if (tmo_q == TmoLast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.mm_start   = mm_start_q;
    // Scratchpad data is already one cycle behind its read, so it pairs with the tag registers
    assign bus.mm_a_data  = a_valid_q ? bus.rd_data : '0;
    assign bus.mm_a_row   = a_row_q;
    assign bus.mm_a_col   = a_col_q;
    assign bus.mm_a_valid = a_valid_q;
    assign bus.mm_b_data  = b_valid_q ? bus.rd_data : '0;
    assign bus.mm_b_row   = b_row_q;
    assign bus.mm_b_col   = b_col_q;
    assign bus.mm_b_valid = b_valid_q;
    assign bus.cmd_done   = cmd_done_q;
    assign bus.err        = err_q;
endmodule
